// File: rtl/lc3_control_pkg.sv
// Shared definitions for the LC-3 control path: opcodes, sequencer states,
// mux/ALU select codes and the bundled control-word type driven by
// lc3_control. Also used by the datapath for the mux code values.
package lc3_control_pkg;

  // Opcodes (ir[15:12]) handled by the sequencer
  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  // pc_mux codes
  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_ADDER = 2'd1;
  localparam logic [1:0] PCMUX_BUS   = 2'd2;

  // addr1_mux codes
  localparam logic ADDR1_PC  = 1'b0;
  localparam logic ADDR1_SR1 = 1'b1;

  // addr2_mux codes
  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  // alu_k codes
  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_DEC,
    S_ALU, S_BR, S_JMP, S_LEA,
    S_EA, S_RD, S_WB, S_SD, S_WR,
    S_HALT
  } state_e;

  // One cycle's worth of control outputs (mem_err is held separately)
  typedef struct packed {
    logic       ld_pc;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_cc;
    logic       load_reg;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       dr_mux;
    logic       sr1_mux;
    logic [1:0] pc_mux;
    logic       addr1_mux;
    logic [1:0] addr2_mux;
    logic [1:0] alu_k;
    logic       mem_en;
    logic       mem_we;
    logic       halted;
  } ctrl_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

endpackage

// File: rtl/lc3_control_wait_timer.sv
// Memory wait timer for the LC-3 sequencer.
// Counts cycles spent waiting on memory and flags the last allowed cycle.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clr_i    : hold the count at zero (sequencer not in a wait state)
//   en_i     : advance the count (waiting, memory not ready)
//   expire_o : current cycle is the WAIT_MAX-th wait cycle; never set when WAIT_MAX = 0
module lc3_control_wait_timer #(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = (WAIT_MAX != 0) && (cnt_q == LAST);

endmodule

// File: rtl/lc3_control.sv
// LC-3 microsequencer: fetch / decode / execute FSM producing the datapath
// control strobes. Supports ADD, AND, NOT, BR, JMP, LEA, LD, LDR, ST, STR.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   ir, n, z, p               : instruction register and condition codes
//   mem_ready                 : memory access completes this cycle
//   ld_*, load_reg            : register load strobes
//   gate_*                    : bus drivers (at most one per cycle)
//   dr_mux, sr1_mux, pc_mux, addr1_mux, addr2_mux, alu_k : datapath selects
//   mem_en, mem_we            : memory strobe / write enable
//   halted, mem_err           : HALT state indicator, sticky wait-timeout flag
module lc3_control
  import lc3_control_pkg::*;
#(
  parameter int unsigned WAIT_MAX     = 0,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ready,
  output logic        ld_pc,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_cc,
  output logic        load_reg,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic        dr_mux,
  output logic        sr1_mux,
  output logic [1:0]  pc_mux,
  output logic        addr1_mux,
  output logic [1:0]  addr2_mux,
  output logic [1:0]  alu_k,
  output logic        mem_en,
  output logic        mem_we,
  output logic        halted,
  output logic        mem_err
);

  state_e     state_q, state_d;
  logic       mem_err_q;
  logic       err_set;
  logic       in_wait;
  logic       tmo;
  ctrl_t      c;
  ctrl_t      o;
  logic [3:0] op;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ^ir[8:0];
  assign in_wait   = (state_q == S_F1) || (state_q == S_RD) || (state_q == S_WR);

  lc3_control_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (!in_wait),
    .en_i     (in_wait && !mem_ready),
    .expire_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    c       = '0;
    err_set = 1'b0;
    case (state_q)
      S_F0: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pc_mux  = PCMUX_INC;
        c.ld_pc   = 1'b1;
        state_d   = S_F1;
      end
      S_F1: begin
        c.mem_en = 1'b1;
        if (mem_ready) begin
          c.ld_mdr = 1'b1;
          state_d  = S_F2;
        end else if (tmo) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_F2: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
        state_d    = S_DEC;
      end
      S_DEC: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT:         state_d = S_ALU;
          OP_BR:                          state_d = S_BR;
          OP_JMP:                         state_d = S_JMP;
          OP_LEA:                         state_d = S_LEA;
          OP_LD, OP_LDR, OP_ST, OP_STR:   state_d = S_EA;
          default:                        state_d = ILLEGAL_HALT ? S_HALT : S_F0;
        endcase
      end
      S_ALU: begin
        c.sr1_mux  = 1'b1;
        c.alu_k    = (op == OP_AND) ? ALUK_AND :
                     (op == OP_NOT) ? ALUK_NOT : ALUK_ADD;
        c.gate_alu = 1'b1;
        c.load_reg = 1'b1;
        c.ld_cc    = 1'b1;
        state_d    = S_F0;
      end
      S_BR: begin
        c.addr1_mux = ADDR1_PC;
        c.addr2_mux = ADDR2_OFF9;
        c.pc_mux    = PCMUX_ADDER;
        c.ld_pc     = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
        state_d     = S_F0;
      end
      S_JMP: begin
        c.sr1_mux   = 1'b1;
        c.addr1_mux = ADDR1_SR1;
        c.addr2_mux = ADDR2_ZERO;
        c.pc_mux    = PCMUX_ADDER;
        c.ld_pc     = 1'b1;
        state_d     = S_F0;
      end
      S_LEA: begin
        c.addr1_mux   = ADDR1_PC;
        c.addr2_mux   = ADDR2_OFF9;
        c.gate_marmux = 1'b1;
        c.load_reg    = 1'b1;
        state_d       = S_F0;
      end
      S_EA: begin
        if (op == OP_LDR || op == OP_STR) begin
          c.sr1_mux   = 1'b1;
          c.addr1_mux = ADDR1_SR1;
          c.addr2_mux = ADDR2_OFF6;
        end else begin
          c.addr1_mux = ADDR1_PC;
          c.addr2_mux = ADDR2_OFF9;
        end
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        state_d       = is_load(op) ? S_RD : S_SD;
      end
      S_RD: begin
        c.mem_en = 1'b1;
        if (mem_ready) begin
          c.ld_mdr = 1'b1;
          state_d  = S_WB;
        end else if (tmo) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        c.gate_mdr = 1'b1;
        c.load_reg = 1'b1;
        c.ld_cc    = 1'b1;
        state_d    = S_F0;
      end
      S_SD: begin
        c.alu_k    = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
        state_d    = S_WR;
      end
      S_WR: begin
        c.mem_en = 1'b1;
        c.mem_we = 1'b1;
        if (mem_ready) begin
          state_d = S_F0;
        end else if (tmo) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        state_d = S_F0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_F0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // rst masks every strobe in the same cycle, so an access interrupted by
  // reset never issues mem_en/mem_we or a load strobe.
  assign o = rst ? '0 : c;

  assign ld_pc       = o.ld_pc;
  assign ld_mar      = o.ld_mar;
  assign ld_mdr      = o.ld_mdr;
  assign ld_ir       = o.ld_ir;
  assign ld_cc       = o.ld_cc;
  assign load_reg    = o.load_reg;
  assign gate_pc     = o.gate_pc;
  assign gate_mdr    = o.gate_mdr;
  assign gate_alu    = o.gate_alu;
  assign gate_marmux = o.gate_marmux;
  assign dr_mux      = o.dr_mux;
  assign sr1_mux     = o.sr1_mux;
  assign pc_mux      = o.pc_mux;
  assign addr1_mux   = o.addr1_mux;
  assign addr2_mux   = o.addr2_mux;
  assign alu_k       = o.alu_k;
  assign mem_en      = o.mem_en;
  assign mem_we      = o.mem_we;
  assign halted      = o.halted;
  assign mem_err     = mem_err_q & ~rst;

endmodule

// File: tb/tb_lc3_control.sv
// Bench for lc3_control: two instances (default parameters, and a
// WAIT_MAX=4 / ILLEGAL_HALT=0 variant) share all inputs. Output words are
// packed as {ld_pc,ld_mar,ld_mdr,ld_ir,ld_cc,load_reg,gate_pc,gate_mdr,
// gate_alu,gate_marmux,dr_mux,sr1_mux,pc_mux[1:0],addr1_mux,addr2_mux[1:0],
// alu_k[1:0],mem_en,mem_we,halted,mem_err}.
module tb_lc3_control;

  localparam logic [22:0] LDPC  = 23'h1 << 22;
  localparam logic [22:0] LDMAR = 23'h1 << 21;
  localparam logic [22:0] LDMDR = 23'h1 << 20;
  localparam logic [22:0] LDIR  = 23'h1 << 19;
  localparam logic [22:0] LDCC  = 23'h1 << 18;
  localparam logic [22:0] LDREG = 23'h1 << 17;
  localparam logic [22:0] GPC   = 23'h1 << 16;
  localparam logic [22:0] GMDR  = 23'h1 << 15;
  localparam logic [22:0] GALU  = 23'h1 << 14;
  localparam logic [22:0] GMM   = 23'h1 << 13;
  localparam logic [22:0] DRM   = 23'h1 << 12;
  localparam logic [22:0] SR1M  = 23'h1 << 11;
  localparam logic [22:0] PCM1  = 23'h1 << 9;
  localparam logic [22:0] A1M   = 23'h1 << 8;
  localparam logic [22:0] A2M1  = 23'h1 << 6;
  localparam logic [22:0] A2M2  = 23'h2 << 6;
  localparam logic [22:0] ALUK1 = 23'h1 << 4;
  localparam logic [22:0] ALUK2 = 23'h2 << 4;
  localparam logic [22:0] ALUK3 = 23'h3 << 4;
  localparam logic [22:0] MEN   = 23'h1 << 3;
  localparam logic [22:0] MWE   = 23'h1 << 2;
  localparam logic [22:0] HLT   = 23'h1 << 1;
  localparam logic [22:0] MERR  = 23'h1;
  localparam logic [22:0] FETCH = GPC | LDMAR | LDPC;
  localparam logic [22:0] ALUOP = SR1M | GALU | LDREG | LDCC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  logic        mem_ready = 1'b0;
  wire  [22:0] obs_m;
  wire  [22:0] obs_t;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  lc3_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_ready(mem_ready),
    .ld_pc(obs_m[22]), .ld_mar(obs_m[21]), .ld_mdr(obs_m[20]), .ld_ir(obs_m[19]),
    .ld_cc(obs_m[18]), .load_reg(obs_m[17]), .gate_pc(obs_m[16]), .gate_mdr(obs_m[15]),
    .gate_alu(obs_m[14]), .gate_marmux(obs_m[13]), .dr_mux(obs_m[12]), .sr1_mux(obs_m[11]),
    .pc_mux(obs_m[10:9]), .addr1_mux(obs_m[8]), .addr2_mux(obs_m[7:6]), .alu_k(obs_m[5:4]),
    .mem_en(obs_m[3]), .mem_we(obs_m[2]), .halted(obs_m[1]), .mem_err(obs_m[0])
  );

  lc3_control #(.WAIT_MAX(4), .ILLEGAL_HALT(1'b0)) dut_t (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_ready(mem_ready),
    .ld_pc(obs_t[22]), .ld_mar(obs_t[21]), .ld_mdr(obs_t[20]), .ld_ir(obs_t[19]),
    .ld_cc(obs_t[18]), .load_reg(obs_t[17]), .gate_pc(obs_t[16]), .gate_mdr(obs_t[15]),
    .gate_alu(obs_t[14]), .gate_marmux(obs_t[13]), .dr_mux(obs_t[12]), .sr1_mux(obs_t[11]),
    .pc_mux(obs_t[10:9]), .addr1_mux(obs_t[8]), .addr2_mux(obs_t[7:6]), .alu_k(obs_t[5:4]),
    .mem_en(obs_t[3]), .mem_we(obs_t[2]), .halted(obs_t[1]), .mem_err(obs_t[0])
  );

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          lo;    // mem_ready low in cycles lo..hi, high otherwise
    int          hi;
    int          ncyc;
  } vec_t;

  typedef struct {
    int          vec;
    int          sel;   // 0: dut, 1: dut_t
    int          cyc;
    logic [22:0] exp;
  } exp_t;

  vec_t vecs[$];
  exp_t exps[$];
  exp_t sb[$];

  function automatic void add_v(input string nm, input logic [15:0] iv, input logic [2:0] nzp,
                                input int lo, input int hi, input int nc);
    vecs.push_back('{nm, iv, nzp, lo, hi, nc});
  endfunction

  function automatic void add_e(input int sel, input int c, input logic [22:0] e);
    exps.push_back('{vecs.size() - 1, sel, c, e});
  endfunction

  task automatic chk(input string tag, input logic [22:0] act, input logic [22:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = rdy;
  endtask

  // cycle 1 = first cycle after reset is released (state F0)
  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  // Scoreboard: pop every expectation due by the current cycle
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t        e;
        logic [22:0] act;
        e = sb.pop_front();
        act = (e.sel != 0) ? obs_t : obs_m;
        n_tests++;
        if (e.cyc != cyc || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s.d%0d.c%0d: got %h at cycle %0d want %h",
                   vecs[e.vec].name, e.sel, e.cyc, act, cyc, e.exp);
        end
      end
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    ir = v.ir;
    {n, z, p} = v.nzp;
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
      chk({v.name, ".rst_m"}, obs_m, '0);
      chk({v.name, ".rst_t"}, obs_t, '0);
    end
    foreach (exps[j]) if (exps[j].vec == i) sb.push_back(exps[j]);
    for (int k = 1; k <= v.ncyc; k++) begin
      drive(1'b0, !(k >= v.lo && k <= v.hi));
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.unconsumed: got %0d pending want 0", v.name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add_v("add", 16'h1042, 3'b000, 1, 0, 6);
    add_e(0, 1, FETCH); add_e(1, 1, FETCH); add_e(0, 2, MEN | LDMDR);
    add_e(0, 3, GMDR | LDIR); add_e(0, 4, '0); add_e(0, 5, ALUOP);
    add_e(1, 5, ALUOP); add_e(0, 6, FETCH);
    add_v("and", 16'h5042, 3'b000, 1, 0, 5);
    add_e(0, 1, FETCH); add_e(0, 5, ALUOP | ALUK1);
    add_v("not", 16'h907F, 3'b000, 1, 0, 5);
    add_e(0, 5, ALUOP | ALUK2);
    add_v("br_z", 16'h0405, 3'b010, 1, 0, 6);
    add_e(0, 5, PCM1 | A2M2 | LDPC); add_e(0, 6, FETCH);
    add_v("br_n_only", 16'h0405, 3'b100, 1, 0, 6);
    add_e(0, 5, PCM1 | A2M2); add_e(0, 6, FETCH);
    add_v("br_p", 16'h0205, 3'b001, 1, 0, 5);
    add_e(0, 5, PCM1 | A2M2 | LDPC);
    add_v("br_never", 16'h0005, 3'b111, 1, 0, 5);
    add_e(0, 5, PCM1 | A2M2);
    add_v("jmp", 16'hC1C0, 3'b000, 1, 0, 6);
    add_e(0, 5, SR1M | A1M | PCM1 | LDPC); add_e(0, 6, FETCH);
    add_v("lea", 16'hE205, 3'b000, 1, 0, 6);
    add_e(0, 5, A2M2 | GMM | LDREG); add_e(0, 6, FETCH);
    add_v("ld_wait3", 16'h2203, 3'b000, 6, 8, 11);
    add_e(0, 5, A2M2 | GMM | LDMAR); add_e(0, 6, MEN); add_e(0, 8, MEN);
    add_e(0, 9, MEN | LDMDR); add_e(1, 9, MEN | LDMDR);
    add_e(0, 10, GMDR | LDREG | LDCC); add_e(1, 10, GMDR | LDREG | LDCC);
    add_e(0, 11, FETCH);
    add_v("ldr", 16'h6283, 3'b000, 1, 0, 8);
    add_e(0, 5, SR1M | A1M | A2M1 | GMM | LDMAR); add_e(0, 6, MEN | LDMDR);
    add_e(0, 7, GMDR | LDREG | LDCC); add_e(0, 8, FETCH);
    add_v("st", 16'h3203, 3'b000, 1, 0, 8);
    add_e(0, 5, A2M2 | GMM | LDMAR); add_e(0, 6, ALUK3 | GALU | LDMDR);
    add_e(0, 7, MEN | MWE); add_e(0, 8, FETCH);
    add_v("str_wait2", 16'h7A41, 3'b000, 7, 8, 10);
    add_e(0, 5, SR1M | A1M | A2M1 | GMM | LDMAR); add_e(0, 6, ALUK3 | GALU | LDMDR);
    add_e(0, 7, MEN | MWE); add_e(0, 8, MEN | MWE); add_e(0, 9, MEN | MWE);
    add_e(0, 10, FETCH);
    add_v("illegal", 16'hD000, 3'b000, 1, 0, 8);
    add_e(0, 5, HLT); add_e(1, 5, FETCH); add_e(0, 8, HLT);
    add_v("timeout", 16'h1042, 3'b000, 2, 20, 22);
    add_e(0, 1, FETCH); add_e(1, 1, FETCH); add_e(0, 2, MEN); add_e(1, 2, MEN);
    add_e(1, 5, MEN); add_e(0, 6, MEN); add_e(1, 6, HLT | MERR);
    add_e(1, 9, HLT | MERR); add_e(0, 21, MEN | LDMDR); add_e(1, 21, HLT | MERR);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Reset arriving in the middle of a read with mem_ready asserted
    ir = 16'h2203;
    {n, z, p} = 3'b000;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("rd_wait", obs_m, MEN);
    drive(1'b1, 1'b1);
    @(negedge clk);
    chk("rst_mid_rd_m", obs_m, '0);
    chk("rst_mid_rd_t", obs_t, '0);
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_f0", obs_m, FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
